// File: rtl/risc_v_mc_controller.sv
// Multi-cycle RISC-V control unit.
// A Moore state machine sequences each instruction through fetch, decode,
// execute and write-back steps. It drives the datapath multiplexer selects,
// the ALU operation and the write strobes. Undecodable instructions park the
// controller in TRAP until reset.
module risc_v_mc_controller #(
    parameter bit MEM_HS      = 1'b0,
    parameter bit FULL_BRANCH = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] func3,
    input  logic       func7,
    input  logic       zero,
    input  logic       neg,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       adrSrc,
    output logic       memWrite,
    output logic       regWrite,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] resultSrc,
    output logic [2:0] ALUControl,
    output logic [2:0] immSrc,
    output logic       illegal
);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXEC_R, S_EXEC_I, S_ALUWB, S_BRANCH, S_JAL, S_JALR_EXE,
        S_JALR_PC, S_LUI, S_TRAP
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;
    localparam logic [2:0] ALU_XOR = 3'b101;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    state_t     state_q, state_d;
    logic       illegal_q, illegal_d;

    logic       mem_go;
    logic [2:0] alu_r_op, alu_i_op;
    logic       alu_legal;
    logic       br_legal, br_take;

    logic       pc_write_c, ir_write_c, adr_src_c, mem_write_c, reg_write_c;
    logic [1:0] alu_src_a_c, alu_src_b_c, result_src_c;
    logic [2:0] alu_ctrl_c, imm_src_c;

    // Memory-holding states advance only on handshake when MEM_HS is set.
    assign mem_go = !MEM_HS || mem_ready;

    // Arithmetic func3 decode shared by register and immediate forms.
    always_comb begin
        alu_r_op  = ALU_ADD;
        alu_i_op  = ALU_ADD;
        alu_legal = 1'b1;
        case (func3)
            3'b000: begin
                alu_r_op = func7 ? ALU_SUB : ALU_ADD;
                alu_i_op = ALU_ADD;
            end
            3'b111: begin alu_r_op = ALU_AND; alu_i_op = ALU_AND; end
            3'b110: begin alu_r_op = ALU_OR;  alu_i_op = ALU_OR;  end
            3'b010: begin alu_r_op = ALU_SLT; alu_i_op = ALU_SLT; end
            3'b100: begin alu_r_op = ALU_XOR; alu_i_op = ALU_XOR; end
            default: alu_legal = 1'b0;
        endcase
    end

    // Branch condition decode; blt/bge exist only in the full branch set.
    always_comb begin
        br_legal = 1'b0;
        br_take  = 1'b0;
        case (func3)
            3'b000: begin br_legal = 1'b1;        br_take = zero;  end
            3'b001: begin br_legal = 1'b1;        br_take = !zero; end
            3'b100: begin br_legal = FULL_BRANCH; br_take = neg;   end
            3'b101: begin br_legal = FULL_BRANCH; br_take = !neg;  end
            default: begin br_legal = 1'b0;       br_take = 1'b0;  end
        endcase
    end

    // Next-state and per-state output decode.
    always_comb begin
        state_d      = state_q;
        pc_write_c   = 1'b0;
        ir_write_c   = 1'b0;
        adr_src_c    = 1'b0;
        mem_write_c  = 1'b0;
        reg_write_c  = 1'b0;
        alu_src_a_c  = 2'b00;
        alu_src_b_c  = 2'b00;
        result_src_c = 2'b00;
        alu_ctrl_c   = ALU_ADD;
        imm_src_c    = IMM_I;
        case (state_q)
            S_FETCH: begin
                alu_src_a_c  = 2'b00;
                alu_src_b_c  = 2'b10;
                result_src_c = 2'b10;
                alu_ctrl_c   = ALU_ADD;
                if (mem_go) begin
                    ir_write_c = 1'b1;
                    pc_write_c = 1'b1;
                    state_d    = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_a_c = 2'b01;
                alu_src_b_c = 2'b01;
                imm_src_c   = (op == OP_JAL) ? IMM_J : IMM_B;
                case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_R:              state_d = S_EXEC_R;
                    OP_I:              state_d = S_EXEC_I;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    OP_JALR:           state_d = S_JALR_EXE;
                    OP_LUI:            state_d = S_LUI;
                    default:           state_d = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                alu_src_a_c = 2'b10;
                alu_src_b_c = 2'b01;
                if (op == OP_LOAD) begin
                    imm_src_c = IMM_I;
                    state_d   = S_MEMREAD;
                end else begin
                    imm_src_c = IMM_S;
                    state_d   = S_MEMWRITE;
                end
            end
            S_MEMREAD: begin
                adr_src_c = 1'b1;
                if (mem_go) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                result_src_c = 2'b01;
                reg_write_c  = 1'b1;
                state_d      = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src_c   = 1'b1;
                mem_write_c = 1'b1;
                if (mem_go) state_d = S_FETCH;
            end
            S_EXEC_R: begin
                alu_src_a_c = 2'b10;
                alu_src_b_c = 2'b00;
                if (alu_legal) begin
                    alu_ctrl_c = alu_r_op;
                    state_d    = S_ALUWB;
                end else begin
                    state_d    = S_TRAP;
                end
            end
            S_EXEC_I: begin
                alu_src_a_c = 2'b10;
                alu_src_b_c = 2'b01;
                imm_src_c   = IMM_I;
                if (alu_legal) begin
                    alu_ctrl_c = alu_i_op;
                    state_d    = S_ALUWB;
                end else begin
                    state_d    = S_TRAP;
                end
            end
            S_ALUWB: begin
                reg_write_c = 1'b1;
                state_d     = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a_c = 2'b10;
                alu_src_b_c = 2'b00;
                alu_ctrl_c  = ALU_SUB;
                pc_write_c  = br_legal && br_take;
                state_d     = br_legal ? S_FETCH : S_TRAP;
            end
            S_JAL: begin
                alu_src_a_c = 2'b01;
                alu_src_b_c = 2'b10;
                pc_write_c  = 1'b1;
                state_d     = S_ALUWB;
            end
            S_JALR_EXE: begin
                alu_src_a_c = 2'b10;
                alu_src_b_c = 2'b01;
                imm_src_c   = IMM_I;
                state_d     = S_JALR_PC;
            end
            S_JALR_PC: begin
                alu_src_a_c = 2'b01;
                alu_src_b_c = 2'b10;
                pc_write_c  = 1'b1;
                state_d     = S_ALUWB;
            end
            S_LUI: begin
                imm_src_c    = IMM_U;
                result_src_c = 2'b11;
                reg_write_c  = 1'b1;
                state_d      = S_FETCH;
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_TRAP;
            end
        endcase
    end

    assign illegal_d = (state_d == S_TRAP);

    // State and trap flag registers; reset restarts at FETCH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    // Write strobes are masked while reset is held so nothing is captured
    // at the edge that follows reset assertion.
    assign PCWrite    = pc_write_c  & ~rst;
    assign IRWrite    = ir_write_c  & ~rst;
    assign memWrite   = mem_write_c & ~rst;
    assign regWrite   = reg_write_c & ~rst;
    assign adrSrc     = adr_src_c;
    assign ALUSrcA    = alu_src_a_c;
    assign ALUSrcB    = alu_src_b_c;
    assign resultSrc  = result_src_c;
    assign ALUControl = alu_ctrl_c;
    assign immSrc     = imm_src_c;
    assign illegal    = illegal_q;

endmodule

// File: tb/tb_risc_v_mc_controller.sv
// Randomised bench for the multi-cycle controller. Two instances run side by
// side: A (handshake on, full branch set) and B (no handshake, beq/bne only).
// Every instruction starts from a reset pulse and the selected instance is
// compared cycle by cycle against a per-instruction expected output trace.
module tb_risc_v_mc_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] op = '0;
    logic [2:0] func3 = '0;
    logic       func7 = 1'b0;
    logic       zero = 1'b0;
    logic       neg = 1'b0;
    logic       mem_ready = 1'b0;

    logic       pcw_a, irw_a, adr_a, mw_a, rw_a, ill_a;
    logic [1:0] asa_a, asb_a, rs_a;
    logic [2:0] alu_a, imm_a;
    logic       pcw_b, irw_b, adr_b, mw_b, rw_b, ill_b;
    logic [1:0] asa_b, asb_b, rs_b;
    logic [2:0] alu_b, imm_b;

    int n_checks = 0;
    int n_fail   = 0;

    logic [17:0] q_exp[$];
    bit          q_rdy[$];

    always #5 clk = ~clk;

    risc_v_mc_controller #(.MEM_HS(1'b1), .FULL_BRANCH(1'b1)) dut_a (
        .clk(clk), .rst(rst), .op(op), .func3(func3), .func7(func7),
        .zero(zero), .neg(neg), .mem_ready(mem_ready),
        .PCWrite(pcw_a), .IRWrite(irw_a), .adrSrc(adr_a), .memWrite(mw_a),
        .regWrite(rw_a), .ALUSrcA(asa_a), .ALUSrcB(asb_a), .resultSrc(rs_a),
        .ALUControl(alu_a), .immSrc(imm_a), .illegal(ill_a)
    );

    risc_v_mc_controller #(.MEM_HS(1'b0), .FULL_BRANCH(1'b0)) dut_b (
        .clk(clk), .rst(rst), .op(op), .func3(func3), .func7(func7),
        .zero(zero), .neg(neg), .mem_ready(mem_ready),
        .PCWrite(pcw_b), .IRWrite(irw_b), .adrSrc(adr_b), .memWrite(mw_b),
        .regWrite(rw_b), .ALUSrcA(asa_b), .ALUSrcB(asb_b), .resultSrc(rs_b),
        .ALUControl(alu_b), .immSrc(imm_b), .illegal(ill_b)
    );

    wire [17:0] obs_a = {pcw_a, irw_a, adr_a, mw_a, rw_a, asa_a, asb_a, rs_a, alu_a, imm_a, ill_a};
    wire [17:0] obs_b = {pcw_b, irw_b, adr_b, mw_b, rw_b, asa_b, asb_b, rs_b, alu_b, imm_b, ill_b};

    task automatic check_val(input string tag, input logic [17:0] obs, input logic [17:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Output vector layout: pcw irw adr mw rw | srcA srcB result | alu imm | illegal
    function automatic logic [17:0] v(bit pcw, bit irw, bit adr, bit mw, bit rw,
                                      logic [1:0] asa, logic [1:0] asb, logic [1:0] rs,
                                      logic [2:0] alu, logic [2:0] imm, bit ill);
        return {pcw, irw, adr, mw, rw, asa, asb, rs, alu, imm, ill};
    endfunction

    // One instruction step; memory steps may be stretched by wait cycles.
    task automatic add_phase(input logic [17:0] go, input logic [17:0] wt,
                             input bit mem, input bit hs, input int waits);
        if (mem && hs) begin
            for (int i = 0; i < waits; i++) begin
                q_exp.push_back(wt);
                q_rdy.push_back(1'b0);
            end
            q_exp.push_back(go);
            q_rdy.push_back(1'b1);
        end else begin
            q_exp.push_back(go);
            q_rdy.push_back(1'($urandom_range(0, 1)));
        end
    endtask

    // Arithmetic operation named by func3 (sub only for register form).
    task automatic alu_ref(input logic [2:0] f3, input bit f7, input bit reg_form,
                           output logic [2:0] code, output bit ok);
        ok = 1'b1;
        code = 3'd0;
        if (f3 == 3'd0)      code = (reg_form && f7) ? 3'd1 : 3'd0;
        else if (f3 == 3'd7) code = 3'd2;
        else if (f3 == 3'd6) code = 3'd3;
        else if (f3 == 3'd2) code = 3'd4;
        else if (f3 == 3'd4) code = 3'd5;
        else ok = 1'b0;
    endtask

    // Build the expected per-cycle trace for one instruction.
    task automatic build(input logic [6:0] o, input logic [2:0] f3, input bit f7,
                         input bit z, input bit n, input bit hs, input bit full,
                         input int wf, input int wm);
        logic [17:0] fetch_go, fetch_wt, aluwb, trap_v;
        logic [2:0]  code;
        bit          ok, trapped, legal, take;
        fetch_go = v(1,1,0,0,0, 2'd0, 2'd2, 2'd2, 3'd0, 3'd0, 0);
        fetch_wt = v(0,0,0,0,0, 2'd0, 2'd2, 2'd2, 3'd0, 3'd0, 0);
        aluwb    = v(0,0,0,0,1, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0, 0);
        trap_v   = v(0,0,0,0,0, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0, 1);
        q_exp.delete();
        q_rdy.delete();
        trapped = 1'b0;
        add_phase(fetch_go, fetch_wt, 1'b1, hs, wf);
        add_phase(v(0,0,0,0,0, 2'd1, 2'd1, 2'd0, 3'd0, (o == 7'h6F) ? 3'd3 : 3'd2, 0), '0, 1'b0, hs, 0);
        case (o)
            7'h03: begin
                add_phase(v(0,0,0,0,0, 2'd2, 2'd1, 2'd0, 3'd0, 3'd0, 0), '0, 1'b0, hs, 0);
                add_phase(v(0,0,1,0,0, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0, 0),
                          v(0,0,1,0,0, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0, 0), 1'b1, hs, wm);
                add_phase(v(0,0,0,0,1, 2'd0, 2'd0, 2'd1, 3'd0, 3'd0, 0), '0, 1'b0, hs, 0);
            end
            7'h23: begin
                add_phase(v(0,0,0,0,0, 2'd2, 2'd1, 2'd0, 3'd0, 3'd1, 0), '0, 1'b0, hs, 0);
                add_phase(v(0,0,1,1,0, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0, 0),
                          v(0,0,1,1,0, 2'd0, 2'd0, 2'd0, 3'd0, 3'd0, 0), 1'b1, hs, wm);
            end
            7'h33, 7'h13: begin
                alu_ref(f3, f7, o == 7'h33, code, ok);
                add_phase(v(0,0,0,0,0, 2'd2, (o == 7'h33) ? 2'd0 : 2'd1, 2'd0,
                            ok ? code : 3'd0, 3'd0, 0), '0, 1'b0, hs, 0);
                if (ok) add_phase(aluwb, '0, 1'b0, hs, 0);
                else trapped = 1'b1;
            end
            7'h63: begin
                legal = (f3 == 3'd0) || (f3 == 3'd1) || (full && (f3 == 3'd4 || f3 == 3'd5));
                take  = (f3 == 3'd0) ? z : (f3 == 3'd1) ? !z : (f3 == 3'd4) ? n : !n;
                add_phase(v(legal && take,0,0,0,0, 2'd2, 2'd0, 2'd0, 3'd1, 3'd0, 0), '0, 1'b0, hs, 0);
                if (!legal) trapped = 1'b1;
            end
            7'h6F: begin
                add_phase(v(1,0,0,0,0, 2'd1, 2'd2, 2'd0, 3'd0, 3'd0, 0), '0, 1'b0, hs, 0);
                add_phase(aluwb, '0, 1'b0, hs, 0);
            end
            7'h67: begin
                add_phase(v(0,0,0,0,0, 2'd2, 2'd1, 2'd0, 3'd0, 3'd0, 0), '0, 1'b0, hs, 0);
                add_phase(v(1,0,0,0,0, 2'd1, 2'd2, 2'd0, 3'd0, 3'd0, 0), '0, 1'b0, hs, 0);
                add_phase(aluwb, '0, 1'b0, hs, 0);
            end
            7'h37: add_phase(v(0,0,0,0,1, 2'd0, 2'd0, 2'd3, 3'd0, 3'd4, 0), '0, 1'b0, hs, 0);
            default: trapped = 1'b1;
        endcase
        if (trapped) begin
            for (int i = 0; i < 3; i++) begin
                q_exp.push_back(trap_v);
                q_rdy.push_back(1'($urandom_range(0, 1)));
            end
        end else begin
            add_phase(fetch_go, fetch_wt, 1'b1, hs, 0);
        end
    endtask

    // Reset, then run one instruction on instance A (sel=0) or B (sel=1).
    task automatic run(input bit sel, input string name, input logic [6:0] o,
                       input logic [2:0] f3, input bit f7, input bit z, input bit n,
                       input int wf, input int wm);
        logic [17:0] obs;
        build(o, f3, f7, z, n, !sel, !sel, wf, wm);
        @(negedge clk);
        rst = 1'b1;
        op = o; func3 = f3; func7 = f7; zero = z; neg = n;
        mem_ready = 1'b1;
        #1;
        obs = sel ? obs_b : obs_a;
        check_val({name, "_rst"}, {13'd0, obs[17:16], obs[14:13], obs[0]}, 18'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < q_exp.size(); i++) begin
            mem_ready = q_rdy[i];
            #1;
            obs = sel ? obs_b : obs_a;
            check_val($sformatf("%s_c%0d", name, i), obs, q_exp[i]);
            @(negedge clk);
        end
    endtask

    // Reset asserted while a store waits for the memory.
    task automatic reset_mid_store();
        @(negedge clk);
        rst = 1'b1;
        op = 7'h23; func3 = 3'd2; func7 = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        mem_ready = 1'b1;                 // FETCH
        @(negedge clk);                   // DECODE
        @(negedge clk);                   // MEMADR
        @(negedge clk);                   // MEMWRITE, stalled
        mem_ready = 1'b0;
        #1;
        check_val("rst_store_mw_before", {17'd0, mw_a}, 18'd1);
        @(posedge clk);
        #2;
        check_val("rst_store_still_wait", {17'd0, mw_a}, 18'd1);
        rst = 1'b1;
        #1;
        check_val("rst_store_mw_async", {13'd0, pcw_a, irw_a, mw_a, rw_a, ill_a}, 18'd0);
        @(negedge clk);
        rst = 1'b0;
        mem_ready = 1'b1;
        #1;
        check_val("rst_store_fetch", obs_a, v(1,1,0,0,0, 2'd0, 2'd2, 2'd2, 3'd0, 3'd0, 0));
        @(negedge clk);
    endtask

    logic [6:0] op_pool [9];

    initial begin
        op_pool = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h00};

        // Directed cases
        run(0, "add",      7'h33, 3'd0, 1'b0, 1'b0, 1'b0, 0, 0);
        run(0, "sub",      7'h33, 3'd0, 1'b1, 1'b0, 1'b0, 0, 0);
        run(0, "lw_wait",  7'h03, 3'd2, 1'b0, 1'b0, 1'b0, 0, 2);
        run(0, "bne_nz",   7'h63, 3'd1, 1'b0, 1'b0, 1'b0, 0, 0);
        run(0, "bne_z",    7'h63, 3'd1, 1'b0, 1'b1, 1'b0, 0, 0);
        run(0, "blt_full", 7'h63, 3'd4, 1'b0, 1'b0, 1'b1, 0, 0);
        run(1, "blt_trap", 7'h63, 3'd4, 1'b0, 1'b0, 1'b1, 0, 0);
        run(0, "jalr",     7'h67, 3'd0, 1'b0, 1'b0, 1'b0, 1, 0);
        run(0, "jal",      7'h6F, 3'd0, 1'b0, 1'b0, 1'b0, 0, 0);
        run(0, "lui",      7'h37, 3'd0, 1'b0, 1'b0, 1'b0, 0, 0);
        run(1, "sw_nohs",  7'h23, 3'd2, 1'b0, 1'b0, 1'b0, 0, 0);
        run(0, "op0",      7'h00, 3'd0, 1'b0, 1'b0, 1'b0, 0, 0);
        reset_mid_store();

        // Randomised instructions on both configurations
        for (int k = 0; k < 80; k++) begin
            logic [6:0] o;
            o = op_pool[$urandom_range(0, 8)];
            if (o == 7'h00) o = 7'($urandom);
            run(k[0], $sformatf("rnd%0d", k), o, 3'($urandom), 1'($urandom),
                1'($urandom), 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/risc_v_mc_controller.md
RISC_V_MC_CONTROLLER -- requirements
Module: risc_v_mc_controller

Interface
REQ-001 Parameter MEM_HS, default 0: 1 = FETCH/MEMREAD/MEMWRITE hold until mem_ready=1; 0 = mem_ready ignored, those states last one cycle.
REQ-002 Parameter FULL_BRANCH, default 1: 1 = beq/bne/blt/bge; 0 = beq/bne only, other branch func3 is illegal.
REQ-003 clk  input  1  system clock, all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 op  input  7  opcode from instruction register.
REQ-006 func3  input  3  instruction func3.
REQ-007 func7  input  1  instruction bit 30.
REQ-008 zero, neg  input  1 each  ALU result zero / negative flags.
REQ-009 mem_ready  input  1  memory access complete.
REQ-010 PCWrite, IRWrite, adrSrc, memWrite, regWrite  output  1 each  PC enable, IR enable, address select (0=PC, 1=ALUOut), store strobe, register-file write.
REQ-011 ALUSrcA  output  2  00=PC, 01=oldPC, 10=rs1.
REQ-012 ALUSrcB  output  2  00=rs2, 01=imm, 10=constant 4.
REQ-013 resultSrc  output  2  00=ALUOut, 01=memory data, 10=ALU result, 11=imm.
REQ-014 ALUControl  output  3  000 add, 001 sub, 010 and, 011 or, 100 slt, 101 xor.
REQ-015 immSrc  output  3  000 I, 001 S, 010 B, 011 J, 100 U.
REQ-016 illegal  output  1  registered, high while in TRAP.

Function
REQ-017 Moore FSM states: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXEC_R, EXEC_I, ALUWB, BRANCH, JAL, JALR_EXE, JALR_PC, LUI, TRAP; all outputs 0 except in the listed states.
REQ-018 FETCH: adrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUControl=add, resultSrc=10, PCWrite=1; advance to DECODE only when ready (REQ-001), IRWrite/PCWrite asserted only in the advancing cycle.
REQ-019 DECODE: ALUSrcA=01, ALUSrcB=01, add, immSrc=B (J when op=1101111); next by op: 0000011/0100011->MEMADR, 0110011->EXEC_R, 0010011->EXEC_I, 1100011->BRANCH, 1101111->JAL, 1100111->JALR_EXE, 0110111->LUI, other->TRAP.
REQ-020 MEMADR: ALUSrcA=10, ALUSrcB=01, add, immSrc=I for load / S for store; ->MEMREAD (load) or MEMWRITE (store).
REQ-021 MEMREAD: adrSrc=1, resultSrc=00; ->MEMWB when ready. MEMWB: resultSrc=01, regWrite=1; ->FETCH.
REQ-022 MEMWRITE: adrSrc=1, resultSrc=00, memWrite=1 every wait cycle; ->FETCH when ready.
REQ-023 EXEC_R: ALUSrcA=10, ALUSrcB=00; func3 000 -> add, or sub if func7=1; 111 and; 110 or; 010 slt; 100 xor; other func3 -> TRAP; else ->ALUWB.
REQ-024 EXEC_I: ALUSrcA=10, ALUSrcB=01, immSrc=I, same func3 decode, func7 ignored (no subi); ->ALUWB.
REQ-025 ALUWB: resultSrc=00, regWrite=1; ->FETCH.
REQ-026 BRANCH: ALUSrcA=10, ALUSrcB=00, sub, resultSrc=00; PCWrite = (000&zero)|(001&!zero)|(100&neg)|(101&!neg); ->FETCH; illegal func3 ->TRAP with PCWrite=0.
REQ-027 JAL: ALUSrcA=01, ALUSrcB=10, add, resultSrc=00, PCWrite=1; ->ALUWB (rd=oldPC+4).
REQ-028 JALR_EXE: ALUSrcA=10, ALUSrcB=01, immSrc=I, add; ->JALR_PC. JALR_PC: ALUSrcA=01, ALUSrcB=10, add, resultSrc=00, PCWrite=1; ->ALUWB.
REQ-029 LUI: immSrc=U, resultSrc=11, regWrite=1; ->FETCH.
REQ-030 TRAP: all strobes 0, illegal=1; absorbing until rst.
REQ-031 CPI: R/I/branch/lui=3-4 (R/I 4, branch 3, lui 3), load 5, store 4, jal 4, jalr 5, plus wait cycles when MEM_HS=1.

Reset
REQ-032 rst asserted at any time, including mid-wait: state->FETCH immediately, illegal=0, no write strobe sampled at the next edge; first fetch begins the cycle after rst deasserts.

Verification
REQ-033 Reset mid-MEMWRITE wait (MEM_HS=1, mem_ready=0) -> memWrite drops asynchronously, state FETCH.
REQ-034 add (op 0110011, f3 000, f7 0) -> FETCH,DECODE,EXEC_R(ALUControl=000),ALUWB(regWrite=1), 4 cycles; f7=1 -> 001.
REQ-035 lw with MEM_HS=1, mem_ready low 2 cycles in MEMREAD -> 7 cycles total, regWrite only in MEMWB.
REQ-036 bne f3=001, zero=0 -> PCWrite=1 in BRANCH; zero=1 -> PCWrite=0; blt with FULL_BRANCH=0 -> TRAP, illegal=1.
REQ-037 jalr -> PCWrite=1 in JALR_PC with ALUSrcA=01, regWrite=1 next cycle with resultSrc=00.
REQ-038 op=0000000 -> DECODE->TRAP, illegal=1 held until rst.
